// File: rtl/mux8_reg_if.sv
// Bus bundle for the registered 8-to-1 read-port selector: eight data
// words, a binary select, and the registered selected word.
interface mux8_reg_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] h;
  logic [2:0]       sel;
  logic [WIDTH-1:0] d_out;

  // Side that supplies the data words and select and consumes the result.
  modport master (
    output a, b, c, d, e, f, g, h, sel,
    input  d_out
  );

  // Side that implements the selector.
  modport slave (
    input  a, b, c, d, e, f, g, h, sel,
    output d_out
  );
endinterface

// File: rtl/mux8_reg.sv
// Registered 8-to-1 word multiplexer for the register-file read path.
// Input k (a..h) is chosen by sel=k and registered on d_out one cycle later.
// The register clears asynchronously while reset_n is low; release is not
// synchronised here, so the first capture is the first rising edge after
// reset_n returns high.
module mux8_reg #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset_n,
  mux8_reg_if.slave bus
);

  logic [WIDTH-1:0] sel_word;

  // Decode the select into the word to be captured at the next edge; an
  // unknown select yields X so a bad select is never masked by a real input.
  always_comb begin
    sel_word = {WIDTH{1'b0}};
    case (bus.sel)
      3'b000:  sel_word = bus.a;
      3'b001:  sel_word = bus.b;
      3'b010:  sel_word = bus.c;
      3'b011:  sel_word = bus.d;
      3'b100:  sel_word = bus.e;
      3'b101:  sel_word = bus.f;
      3'b110:  sel_word = bus.g;
      3'b111:  sel_word = bus.h;
      default: sel_word = {WIDTH{1'bx}};
    endcase
  end

  // Output register: cleared by reset, otherwise loads the selected word every edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.d_out <= {WIDTH{1'b0}};
    end else begin
      bus.d_out <= sel_word;
    end
  end

endmodule

// File: tb/tb_mux8_reg.sv
// Directed self-checking bench for mux8_reg.
module tb_mux8_reg;

  localparam int WIDTH = 32;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  mux8_reg_if #(.WIDTH(WIDTH)) bus ();

  mux8_reg #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (bus.d_out !== exp) begin
      n_fail++;
      $display("FAIL %s: d_out=%h expected=%h at %0t", name, bus.d_out, exp, $time);
    end
  endtask

  task automatic load_pattern();
    bus.a = 32'h0000_0000;
    bus.b = 32'h1111_1111;
    bus.c = 32'h2222_2222;
    bus.d = 32'h3333_3333;
    bus.e = 32'h4444_4444;
    bus.f = 32'h5555_5555;
    bus.g = 32'h6666_6666;
    bus.h = 32'h7777_7777;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load_pattern();
    bus.sel = 3'b111;
    #2;
    check("reset_initial", 32'h0000_0000);
    tick();
    check("reset_hold_edge", 32'h0000_0000);
    reset_n = 1'b1;
    tick();
    check("reset_first_capture", 32'h7777_7777);
    // Assert reset mid-cycle: output must clear without an edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_async_clear", 32'h0000_0000);
    tick();
    check("reset_still_low", 32'h0000_0000);
    #2;
    reset_n = 1'b1;
    #1;
    check("reset_release_no_edge", 32'h0000_0000);
    tick();
    check("reset_release_capture", 32'h7777_7777);
  endtask

  task automatic test_sweep();
    logic [WIDTH-1:0] exp;
    load_pattern();
    for (int k = 0; k < 8; k++) begin
      bus.sel = 3'(k);
      tick();
      exp = 32'h1111_1111 * 32'(k);
      check($sformatf("sweep_sel%0d", k), exp);
    end
  endtask

  task automatic test_latency();
    load_pattern();
    bus.sel = 3'b010;
    tick();
    check("latency_sel2", 32'h2222_2222);
    #3;
    bus.sel = 3'b101;
    #1;
    check("latency_hold_between_edges", 32'h2222_2222);
    tick();
    check("latency_sel5", 32'h5555_5555);
  endtask

  task automatic test_data_change();
    load_pattern();
    bus.sel = 3'b111;
    tick();
    check("data_h_initial", 32'h7777_7777);
    bus.h = 32'hDEAD_BEEF;
    #2;
    check("data_h_before_edge", 32'h7777_7777);
    tick();
    check("data_h_changed", 32'hDEAD_BEEF);
    bus.a = 32'hA5A5_A5A5;
    bus.b = 32'h0123_4567;
    bus.c = 32'h89AB_CDEF;
    bus.d = 32'hFFFF_0000;
    bus.e = 32'h0000_FFFF;
    bus.f = 32'h1357_9BDF;
    bus.g = 32'h2468_ACE0;
    tick();
    check("data_others_ignored", 32'hDEAD_BEEF);
  endtask

  task automatic test_reset_mid_sweep();
    load_pattern();
    bus.sel = 3'b100;
    tick();
    check("midsweep_before", 32'h4444_4444);
    #2;
    reset_n = 1'b0;
    #1;
    check("midsweep_in_reset", 32'h0000_0000);
    tick();
    check("midsweep_reset_edge", 32'h0000_0000);
    #2;
    reset_n = 1'b1;
    tick();
    check("midsweep_after_release", 32'h4444_4444);
  endtask

  task automatic test_extremes();
    logic [WIDTH-1:0] exp;
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'h0000_0000;
    for (int i = 0; i < 6; i++) begin
      bus.sel = 3'(i % 2);
      tick();
      exp = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
      check($sformatf("extreme_%0d", i), exp);
    end
  endtask

  task automatic test_back_to_back();
    load_pattern();
    bus.sel = 3'b000;
    tick();
    check("b2b_start", 32'h0000_0000);
    // Select and its data change together: the new word must win whole.
    bus.sel = 3'b011;
    bus.d   = 32'hCAFE_F00D;
    bus.a   = 32'h1234_5678;
    tick();
    check("b2b_new_sel_new_data", 32'hCAFE_F00D);
    bus.sel = 3'b000;
    tick();
    check("b2b_back_to_a", 32'h1234_5678);
    bus.sel = 3'b110;
    tick();
    check("b2b_sel6", 32'h6666_6666);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.sel  = 3'b000;
    test_reset();
    test_sweep();
    test_latency();
    test_data_change();
    test_reset_mid_sweep();
    test_extremes();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
